// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller.
// Produces the PC / IF/ID / ID/EX enables, flushes and bubbles, plus a
// whole-pipe hold while a data-memory access is outstanding. A watchdog
// latches a sticky error if the memory does not answer in time.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   id_rs1/rs2, id_uses_*  source registers of the ID instruction
//   ex_rd, ex_reg_we,
//   ex_mem_to_reg          destination / load info of the EX instruction
//   ex_branch_taken        taken branch resolved in EX
//   mem_req, mem_ready     MEM-stage access handshake
//   pc_write, if_id_write  fetch-side load enables
//   if_id_flush,
//   id_ex_flush,
//   id_ex_bubble           squash / bubble controls
//   pipe_hold              freeze ID/EX, EX/MEM, MEM/WB
//   hazard_cause           previous cycle's cause (0 none,1 load-use,2 branch,3 mem)
//   mem_timeout            sticky watchdog error
//   stall_cycles,
//   flush_count            performance counters
//
// Build option: define HAZARD_PERF_EN to implement the saturating
// performance counters; otherwise both counter ports are tied to 0.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_we,
  input  logic             ex_mem_to_reg,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_flush,
  output logic             pipe_hold,
  output logic [1:0]       hazard_cause,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WCW = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

  state_t         state, state_nxt, state_eff;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic [1:0]     cause_nxt;
  logic           load_use, mem_stall, freeze, br_sel;

  assign load_use  = ex_mem_to_reg & ex_reg_we & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign mem_stall = mem_req & ~mem_ready;
  // During a reset cycle the outputs behave as if the FSM were already in RUN.
  assign state_eff = reset ? RUN : state;
  assign freeze    = mem_stall | (state_eff == ERR);
  assign br_sel    = ~freeze & ex_branch_taken;

  // Priority-encoded control outputs: freeze > branch > load-use > normal.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    cause_nxt    = 2'd0;
    if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
      cause_nxt   = 2'd3;
    end else if (ex_branch_taken) begin
      // A coincident load-use is ignored: the dependent instruction is squashed.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      cause_nxt   = 2'd2;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      cause_nxt    = 2'd1;
    end
  end

  // Memory-wait watchdog FSM.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: if (mem_stall) begin
        state_nxt    = WAIT;
        wait_cnt_nxt = WCW'(1);
      end
      WAIT: begin
        if (!mem_stall) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + WCW'(1);
        end
      end
      default: state_nxt = ERR;  // ERR holds until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      hazard_cause <= 2'd0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      hazard_cause <= cause_nxt;
    end
  end

  assign mem_timeout = (state == ERR);

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((freeze | load_use) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (br_sel && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
  logic unused_perf;
  assign unused_perf = br_sel;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=3).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled mid-cycle and registered outputs after the following edge.
module tb_hazard_ctrl;
  localparam int MT = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_reg_we, ex_mem_to_reg;
  logic          ex_branch_taken, mem_req, mem_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_flush, pipe_hold;
  logic [1:0]    hazard_cause;
  logic          mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .id_ex_flush(id_ex_flush), .pipe_hold(pipe_hold),
    .hazard_cause(hazard_cause), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance to 1 unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mid-cycle sample point (inputs already settled)
  task automatic settle();
    #3;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 0; ex_reg_we = 0; ex_mem_to_reg = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    ex_mem_to_reg = 1; ex_reg_we = 1; ex_rd = rd;
  endtask

  // pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_bubble, pipe_hold
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_bubble, pipe_hold}, exp);
  endtask

  localparam logic [5:0] C_RUN    = 6'b110000;
  localparam logic [5:0] C_LU     = 6'b000010;
  localparam logic [5:0] C_BR     = 6'b111100;
  localparam logic [5:0] C_FREEZE = 6'b000001;

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    settle();
    // reset state
    chk("rst_cause", hazard_cause, 0);
    chk("rst_timeout", mem_timeout, 0);
    chk_ctl("rst_ctl", C_RUN);
    chk("rst_stall_cnt", stall_cycles, 0);
    chk("rst_flush_cnt", flush_count, 0);

    // load-use through rs2
    tick();
    set_load(5'd5); id_rs2 = 5; id_uses_rs2 = 1;
    settle(); chk_ctl("lu_rs2", C_LU);
    tick(); idle();
    settle(); chk_ctl("lu_release", C_RUN);
    chk("lu_cause", hazard_cause, 1);

    // x0 destination is never a hazard
    tick();
    set_load(5'd0); id_rs2 = 0; id_uses_rs2 = 1;
    settle(); chk_ctl("lu_x0", C_RUN);
    tick(); idle();
    settle(); chk("lu_x0_cause", hazard_cause, 0);

    // rs1 match, then same registers with id_uses_rs1 low
    tick();
    set_load(5'd7); id_rs1 = 7; id_uses_rs1 = 1;
    settle(); chk_ctl("lu_rs1", C_LU);
    tick();
    id_uses_rs1 = 0;
    settle(); chk_ctl("lu_rs1_unused", C_RUN);
    // non-load writer with matching rd
    tick();
    ex_mem_to_reg = 0; id_uses_rs1 = 1;
    settle(); chk_ctl("no_load", C_RUN);

    // branch together with load-use: branch wins
    tick(); idle();
    set_load(5'd9); id_rs1 = 9; id_uses_rs1 = 1; ex_branch_taken = 1;
    settle(); chk_ctl("br_lu", C_BR);
    tick(); idle();
    settle(); chk("br_cause", hazard_cause, 2);
`ifdef HAZARD_PERF_EN
    chk("br_flush_cnt", flush_count, 1);
`else
    chk("br_flush_cnt", flush_count, 0);
`endif

    // memory wait with a deferred branch
    tick();
    mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      settle(); chk_ctl($sformatf("mw_freeze%0d", i), C_FREEZE);
      tick();
      chk($sformatf("mw_cause%0d", i), hazard_cause, 3);
    end
    mem_ready = 1;
    settle(); chk_ctl("mw_release", C_BR);
    tick();
    chk("mw_rel_cause", hazard_cause, 2);
    idle();
    settle(); chk_ctl("mw_run", C_RUN);
    chk("mw_no_timeout", mem_timeout, 0);

    // watchdog: 4 consecutive wait cycles
    tick();
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= MT; i++) begin
      tick();
      chk($sformatf("wd_to%0d", i), mem_timeout, (i == MT) ? 1 : 0);
    end
    mem_ready = 1;
    settle(); chk_ctl("wd_frozen_ready", C_FREEZE);
    tick();
    chk("wd_cause", hazard_cause, 3);
    mem_req = 0;
    settle(); chk_ctl("wd_frozen_idle", C_FREEZE);
    tick();
    reset = 1;
    settle(); chk_ctl("wd_rst_cycle", C_RUN);
    tick();
    reset = 0;
    settle();
    chk("wd_rst_timeout", mem_timeout, 0);
    chk("wd_rst_cause", hazard_cause, 0);
    chk_ctl("wd_rst_run", C_RUN);
    chk("wd_rst_flush_cnt", flush_count, 0);

    // 10 consecutive load-use cycles: stall counter saturates
    tick();
    set_load(5'd3); id_rs2 = 3; id_uses_rs2 = 1;
    for (int i = 0; i < 10; i++) tick();
    idle();
    settle();
`ifdef HAZARD_PERF_EN
    chk("sat_stall_cnt", stall_cycles, 7);
`else
    chk("sat_stall_cnt", stall_cycles, 0);
`endif

    // reset on the 2nd wait cycle
    tick();
    mem_req = 1; mem_ready = 0;
    tick();
    reset = 1;
    tick();
    reset = 0; mem_req = 0;
    settle();
    chk("rw_cause", hazard_cause, 0);
    chk("rw_wait_cnt", dut.wait_cnt, 0);
    chk_ctl("rw_run", C_RUN);
    tick();
    mem_req = 1;
    tick();
    chk("rw_fresh_cnt", dut.wait_cnt, 1);
    for (int i = 2; i <= MT; i++) begin
      tick();
      chk($sformatf("rw_to%0d", i), mem_timeout, (i == MT) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
